// File: rtl/rc_pwm_decoder.sv
// rc_pwm_decoder
// Measures the high time of the four RC receiver PWM channels and converts
// each pulse into an 8-bit offset. Each channel has its own IDLE/MEASURE
// FSM, glitch/over-length rejection and loss-of-signal timeout.
// Channel index order everywhere is {yaw, roll, pitch, throttle} = {3,2,1,0}.
module rc_pwm_decoder #(
    parameter int US_DIV     = 50,     // clk cycles per microsecond tick
    parameter int MIN_US     = 1000,   // pulse width that maps to offset 0
    parameter int GLITCH_US  = 800,    // shorter pulses are discarded
    parameter int MAX_US     = 2500,   // longer pulses are discarded
    parameter int TIMEOUT_US = 25000   // no valid pulse for this long -> lost
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       throttle_pwm,
    input  logic       pitch_pwm,
    input  logic       roll_pwm,
    input  logic       yaw_pwm,
    output logic [7:0] throttle_offset,
    output logic [7:0] pitch_offset,
    output logic [7:0] roll_offset,
    output logic [7:0] yaw_offset,
    output logic [3:0] update,
    output logic [3:0] ch_valid,
    output logic       link_ok
);

    localparam int NCH  = 4;
    localparam int PS_W = (US_DIV > 1) ? $clog2(US_DIV) : 1;

    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(US_DIV - 1);
    localparam logic [11:0]     MIN_W     = 12'(MIN_US);
    localparam logic [11:0]     GLITCH_W  = 12'(GLITCH_US);
    localparam logic [11:0]     MAX_W     = 12'(MAX_US);
    localparam logic [11:0]     WIDTH_SAT = 12'hFFF;
    localparam logic [14:0]     TIMEOUT_W = 15'(TIMEOUT_US);
    localparam logic [14:0]     TO_SAT    = 15'h7FFF;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } ch_state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // A pulse is usable only inside the [GLITCH_US, MAX_US] window.
    function automatic logic width_in_range(input logic [11:0] w);
        return (w >= GLITCH_W) && (w <= MAX_W);
    endfunction

    // (width - MIN_US) / 4, floored at 0 and saturated to 8 bits.
    function automatic logic [7:0] decode_offset(input logic [11:0] w);
        logic [11:0] d;
        if (w < MIN_W) begin
            d = 12'd0;
        end else begin
            d = (w - MIN_W) >> 2;
        end
        if (d > 12'd255) begin
            return 8'hFF;
        end
        return d[7:0];
    endfunction

    // Failsafe: throttle to zero, stick axes to centre.
    function automatic logic [7:0] failsafe_offset(input int ch);
        return (ch == 0) ? 8'd0 : 8'd128;
    endfunction

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [NCH-1:0]  pwm_raw;
    logic [NCH-1:0]  pwm_p0;
    logic [NCH-1:0]  pwm_p1;
    logic [NCH-1:0]  pwm_p2;
    logic [NCH-1:0]  rise;
    logic [NCH-1:0]  fall;

    logic [PS_W-1:0] ps_cnt;
    logic            tick;

    ch_state_t       state_q [NCH];
    ch_state_t       state_d [NCH];
    logic [11:0]     width_q [NCH];
    logic [14:0]     to_cnt_q [NCH];
    logic [7:0]      offset_q [NCH];

    logic [NCH-1:0]  pulse_ok;
    logic [NCH-1:0]  expired;
    logic [NCH-1:0]  update_q;
    logic [NCH-1:0]  ch_valid_q;
    logic            link_ok_q;

    assign pwm_raw = {yaw_pwm, roll_pwm, pitch_pwm, throttle_pwm};

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF synchronizer plus one FF for edge detect
    // ------------------------------------------------------------------

    // Reset the chain to '1' so a line that is already high when reset is
    // released never looks like a rising edge; a low line only produces a
    // fall, which IDLE ignores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_p0 <= '1;
            pwm_p1 <= '1;
            pwm_p2 <= '1;
        end else begin
            pwm_p0 <= pwm_raw;
            pwm_p1 <= pwm_p0;
            pwm_p2 <= pwm_p1;
        end
    end

    assign rise = pwm_p1 & ~pwm_p2;
    assign fall = ~pwm_p1 & pwm_p2;

    // ------------------------------------------------------------------
    // Shared microsecond prescaler
    // ------------------------------------------------------------------

    // Free-running 0..US_DIV-1 counter; tick is high on its last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt <= '0;
        end else if (ps_cnt == PS_LAST) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    assign tick = (ps_cnt == PS_LAST);

    // ------------------------------------------------------------------
    // Per-channel IDLE / MEASURE FSM
    // ------------------------------------------------------------------

    // State register for all channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Next state and pulse evaluation; a fall in MEASURE ends the pulse.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i]  = state_q[i];
            pulse_ok[i] = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if (rise[i]) begin
                        state_d[i] = MEASURE;
                    end
                end
                MEASURE: begin
                    if (fall[i]) begin
                        pulse_ok[i] = width_in_range(width_q[i]);
                        state_d[i]  = IDLE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase
        end
    end

    // Pulse width in microseconds. The tick of the rise cycle is counted
    // so the measured span runs from the rise cycle up to the fall cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                width_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (state_q[i] == IDLE) begin
                    if (rise[i]) begin
                        width_q[i] <= {11'd0, tick};
                    end
                end else if (!fall[i] && tick && (width_q[i] != WIDTH_SAT)) begin
                    width_q[i] <= width_q[i] + 12'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Loss-of-signal timeout
    // ------------------------------------------------------------------

    // Microseconds since the last valid pulse, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                to_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (pulse_ok[i]) begin
                    to_cnt_q[i] <= '0;
                end else if (tick && (to_cnt_q[i] != TO_SAT)) begin
                    to_cnt_q[i] <= to_cnt_q[i] + 15'd1;
                end
            end
        end
    end

    // Channel is lost once its counter has reached the timeout.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            expired[i] = (to_cnt_q[i] >= TIMEOUT_W);
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------

    // Offset/valid/strobe update; a valid pulse takes priority over expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                offset_q[i] <= failsafe_offset(i);
            end
            update_q   <= '0;
            ch_valid_q <= '0;
        end else begin
            update_q <= pulse_ok;
            for (int i = 0; i < NCH; i++) begin
                if (pulse_ok[i]) begin
                    offset_q[i]   <= decode_offset(width_q[i]);
                    ch_valid_q[i] <= 1'b1;
                end else if (expired[i]) begin
                    offset_q[i]   <= failsafe_offset(i);
                    ch_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Link status trails the per-channel valid flags by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_ok_q <= 1'b0;
        end else begin
            link_ok_q <= &ch_valid_q;
        end
    end

    assign throttle_offset = offset_q[0];
    assign pitch_offset    = offset_q[1];
    assign roll_offset     = offset_q[2];
    assign yaw_offset      = offset_q[3];
    assign update          = update_q;
    assign ch_valid        = ch_valid_q;
    assign link_ok         = link_ok_q;

endmodule

// File: tb/tb_rc_pwm_decoder.sv
// Directed testbench for rc_pwm_decoder. The DUT runs with one tick per
// clock (one cycle = one microsecond) and a 5000 us timeout so every
// scenario fits in a short run; offset arithmetic is unchanged.
module tb_rc_pwm_decoder;

    logic       clk;
    logic       rst_n;
    logic [3:0] pwm;
    logic [7:0] thr_off;
    logic [7:0] pit_off;
    logic [7:0] rol_off;
    logic [7:0] yaw_off;
    logic [3:0] update;
    logic [3:0] ch_valid;
    logic       link_ok;

    int n_tests;
    int n_fail;
    int upd_cnt [4];
    int all_cnt;

    rc_pwm_decoder #(
        .US_DIV     (1),
        .MIN_US     (1000),
        .GLITCH_US  (800),
        .MAX_US     (2500),
        .TIMEOUT_US (5000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .throttle_pwm    (pwm[0]),
        .pitch_pwm       (pwm[1]),
        .roll_pwm        (pwm[2]),
        .yaw_pwm         (pwm[3]),
        .throttle_offset (thr_off),
        .pitch_offset    (pit_off),
        .roll_offset     (rol_off),
        .yaw_offset      (yaw_off),
        .update          (update),
        .ch_valid        (ch_valid),
        .link_ok         (link_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count update strobes per channel and all-four-together strobes.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (update[i]) upd_cnt[i] = upd_cnt[i] + 1;
        end
        if (update == 4'hF) all_cnt = all_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Raise the selected pins together at a falling clock edge, hold each
    // high for its width in cycles (0 = no pulse), then stay low for gap.
    task automatic drive(input int w0, input int w1, input int w2, input int w3, input int gap);
        int w [4];
        int mx;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        mx = 0;
        for (int i = 0; i < 4; i++) if (w[i] > mx) mx = w[i];
        for (int c = 0; c < mx; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) pwm[i] = (c < w[i]);
        end
        @(negedge clk);
        pwm = 4'b0000;
        repeat (gap) @(negedge clk);
    endtask

    int snap;
    int snap_all;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        all_cnt = 0;
        for (int i = 0; i < 4; i++) upd_cnt[i] = 0;
        pwm   = 4'b0000;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);

        // Reset values
        check("rst_thr",   32'(thr_off),  32'd0);
        check("rst_pit",   32'(pit_off),  32'd128);
        check("rst_rol",   32'(rol_off),  32'd128);
        check("rst_yaw",   32'(yaw_off),  32'd128);
        check("rst_upd",   32'(update),   32'd0);
        check("rst_valid", 32'(ch_valid), 32'd0);
        check("rst_link",  32'(link_ok),  32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single 1500 us pitch pulse
        drive(0, 1500, 0, 0, 50);
        check("p1_pit",     32'(pit_off),    32'd125);
        check("p1_upd_pit", 32'(upd_cnt[1]), 32'd1);
        check("p1_upd_oth", 32'(upd_cnt[0] + upd_cnt[2] + upd_cnt[3]), 32'd0);
        check("p1_valid",   32'(ch_valid),   32'b0010);
        check("p1_thr",     32'(thr_off),    32'd0);
        check("p1_rol",     32'(rol_off),    32'd128);
        check("p1_yaw",     32'(yaw_off),    32'd128);
        check("p1_link",    32'(link_ok),    32'd0);

        // Throttle mapping, clamp and below-minimum
        drive(1000, 0, 0, 0, 50);
        check("thr_1000", 32'(thr_off), 32'd0);
        drive(2000, 0, 0, 0, 50);
        check("thr_2000", 32'(thr_off), 32'd250);
        drive(2200, 0, 0, 0, 50);
        check("thr_2200", 32'(thr_off), 32'd255);
        drive(950, 0, 0, 0, 50);
        check("thr_950",  32'(thr_off), 32'd0);
        check("thr_upds", 32'(upd_cnt[0]), 32'd4);

        // Roll: good pulse, then a glitch and an over-length pulse
        drive(0, 0, 1800, 0, 50);
        check("rol_1800", 32'(rol_off), 32'd200);
        snap = upd_cnt[2];
        drive(0, 0, 700, 0, 50);
        check("rol_700",      32'(rol_off),    32'd200);
        check("rol_700_upd",  32'(upd_cnt[2]), 32'(snap));
        drive(0, 0, 3000, 0, 50);
        check("rol_3000",     32'(rol_off),    32'd200);
        check("rol_3000_upd", 32'(upd_cnt[2]), 32'(snap));
        check("rol_valid",    32'(ch_valid[2]), 32'd1);

        // Link up with all channels, then yaw loss and recovery
        drive(1500, 1500, 1500, 1500, 2500);
        drive(1500, 1500, 1500, 1500, 2500);
        check("lk_link", 32'(link_ok), 32'd1);
        check("lk_offs", 32'({thr_off, pit_off, rol_off, yaw_off}), 32'h7D7D7D7D);
        snap = upd_cnt[3];
        drive(1500, 1500, 1500, 0, 800);
        check("to_pre_valid", 32'(ch_valid), 32'hF);
        check("to_pre_yaw",   32'(yaw_off),  32'd125);
        repeat (300) @(negedge clk);
        check("to_valid", 32'(ch_valid),   32'b0111);
        check("to_yaw",   32'(yaw_off),    32'd128);
        check("to_link",  32'(link_ok),    32'd0);
        check("to_upd",   32'(upd_cnt[3]), 32'(snap));
        drive(0, 0, 0, 1600, 50);
        check("rec_yaw",   32'(yaw_off),  32'd150);
        check("rec_valid", 32'(ch_valid), 32'hF);
        check("rec_link",  32'(link_ok),  32'd1);

        // Reset in the middle of a throttle pulse
        snap = upd_cnt[0];
        @(negedge clk);
        pwm[0] = 1'b1;
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("mr_thr_rst",   32'(thr_off),  32'd0);
        check("mr_valid_rst", 32'(ch_valid), 32'd0);
        check("mr_pit_rst",   32'(pit_off),  32'd128);
        rst_n = 1'b1;
        repeat (1195) @(negedge clk);
        pwm[0] = 1'b0;
        repeat (50) @(negedge clk);
        check("mr_no_upd", 32'(upd_cnt[0]), 32'(snap));
        check("mr_thr",    32'(thr_off),    32'd0);
        drive(1400, 0, 0, 0, 50);
        check("mr_thr_1400", 32'(thr_off), 32'd100);

        // Simultaneous falls on all channels
        snap_all = all_cnt;
        drive(1200, 1200, 1200, 1200, 50);
        check("sim_all_upd", 32'(all_cnt - snap_all), 32'd1);
        check("sim_offs", 32'({thr_off, pit_off, rol_off, yaw_off}), 32'h32323232);
        check("sim_valid", 32'(ch_valid), 32'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
